// File: rtl/shape_sfr_arbiter.sv
// shape_sfr_arbiter: round-robin sharing of the shape processor control SFR
// between two requesters, with optional read-back confirmation of each write.
module shape_sfr_arbiter #(
    parameter bit READBACK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_shape,
    input  logic [4:0]  req0_operation,
    output logic        resp0_valid,
    output logic [1:0]  resp0_status,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_shape,
    input  logic [4:0]  req1_operation,
    output logic        resp1_valid,
    output logic [1:0]  resp1_status,
    output logic        sp_write,
    output logic [31:0] sp_write_data,
    output logic        sp_read,
    input  logic [31:0] sp_read_data,
    input  logic        sp_error,
    output logic [7:0]  reject_count
);

    localparam int unsigned SHAPE_W   = 2;
    localparam int unsigned OP_W      = 5;
    localparam int unsigned PAD_HI_W  = 14;
    localparam int unsigned PAD_LO_W  = 11;
    localparam int unsigned SHAPE_LSB = 16;
    localparam int unsigned CNT_W     = 8;

    localparam logic [1:0]       ST_OK   = 2'b00;
    localparam logic [1:0]       ST_REJ  = 2'b01;
    localparam logic [1:0]       ST_ERR  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic [SHAPE_W-1:0] shape;
        logic [OP_W-1:0]    operation;
    } cmd_t;

    state_t state_q;
    state_t state_d;

    cmd_t cmd_q;
    logic id_q;
    logic last_grant_q;

    logic gnt0_c;
    logic gnt1_c;
    logic take_c;

    logic [SHAPE_W-1:0] rd_shape_c;
    logic [OP_W-1:0]    rd_op_c;
    logic [1:0]         status_c;
    logic               resp_pulse_c;

    logic             sp_write_d;
    logic             sp_read_d;
    logic             resp0_valid_d;
    logic             resp1_valid_d;
    logic [1:0]       resp0_status_d;
    logic [1:0]       resp1_status_d;
    logic [CNT_W-1:0] reject_count_d;

    // Only the shape and operation fields of the read-back are compared.
    logic unused_rd_c;
    assign unused_rd_c = ^{sp_read_data[31:SHAPE_LSB+SHAPE_W], sp_read_data[SHAPE_LSB-1:OP_W]};

    assign rd_shape_c = sp_read_data[SHAPE_LSB +: SHAPE_W];
    assign rd_op_c    = sp_read_data[OP_W-1:0];

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                gnt0_c = last_grant_q;
                gnt1_c = !last_grant_q;
            end else begin
                gnt0_c = req0_valid;
                gnt1_c = req1_valid;
            end
        end
    end

    assign take_c     = gnt0_c || gnt1_c;
    assign req0_ready = gnt0_c;
    assign req1_ready = gnt1_c;

    // Write data is decoded straight from the latched command.
    assign sp_write_data = {{PAD_HI_W{1'b0}}, cmd_q.shape, {PAD_LO_W{1'b0}}, cmd_q.operation};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take_c) state_d = WRITE;
            WRITE:   state_d = READBACK ? READ : RESP;
            READ:    state_d = CHECK;
            CHECK:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the state being entered.
    always_comb begin
        status_c       = ST_OK;
        sp_write_d     = 1'b0;
        sp_read_d      = 1'b0;
        resp_pulse_c   = 1'b0;
        resp0_valid_d  = 1'b0;
        resp1_valid_d  = 1'b0;
        resp0_status_d = resp0_status;
        resp1_status_d = resp1_status;
        reject_count_d = reject_count;

        // Processor error outranks a read-back mismatch.
        if (sp_error) begin
            status_c = ST_ERR;
        end else if (state_q == CHECK &&
                     (rd_shape_c != cmd_q.shape || rd_op_c != cmd_q.operation)) begin
            status_c = ST_REJ;
        end

        sp_write_d   = (state_d == WRITE);
        sp_read_d    = (state_d == READ);
        resp_pulse_c = (state_d == RESP);

        resp0_valid_d = resp_pulse_c && !id_q;
        resp1_valid_d = resp_pulse_c && id_q;
        if (resp0_valid_d) resp0_status_d = status_c;
        if (resp1_valid_d) resp1_status_d = status_c;

        if (resp_pulse_c && status_c != ST_OK && reject_count != CNT_MAX) begin
            reject_count_d = reject_count + CNT_W'(1);
        end
    end

    // Latch the granted command, its issuer and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (take_c) begin
            cmd_q        <= gnt1_c ? cmd_t'{req1_shape, req1_operation}
                                   : cmd_t'{req0_shape, req0_operation};
            id_q         <= gnt1_c;
            last_grant_q <= gnt1_c;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_write     <= 1'b0;
            sp_read      <= 1'b0;
            resp0_valid  <= 1'b0;
            resp1_valid  <= 1'b0;
            resp0_status <= ST_OK;
            resp1_status <= ST_OK;
            reject_count <= '0;
        end else begin
            sp_write     <= sp_write_d;
            sp_read      <= sp_read_d;
            resp0_valid  <= resp0_valid_d;
            resp1_valid  <= resp1_valid_d;
            resp0_status <= resp0_status_d;
            resp1_status <= resp1_status_d;
            reject_count <= reject_count_d;
        end
    end

    // Structural invariants of the handshake and SFR strobes.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));
    a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp0_valid && resp1_valid));
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(sp_write && sp_read));

endmodule

// File: tb/tb_shape_sfr_arbiter.sv
// Bench for shape_sfr_arbiter: directed and randomized commands against a
// behavioural model of the arbitration and status rules.
module tb_shape_sfr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Read-back build
    logic        req0_valid, req0_ready, resp0_valid;
    logic [1:0]  req0_shape, resp0_status;
    logic [4:0]  req0_operation;
    logic        req1_valid, req1_ready, resp1_valid;
    logic [1:0]  req1_shape, resp1_status;
    logic [4:0]  req1_operation;
    logic        sp_write, sp_read, sp_error;
    logic [31:0] sp_write_data, sp_read_data;
    logic [7:0]  reject_count;

    // No-read-back build
    logic        b_req0_valid, b_req0_ready, b_resp0_valid;
    logic [1:0]  b_req0_shape, b_resp0_status;
    logic [4:0]  b_req0_operation;
    logic        b_req1_valid, b_req1_ready, b_resp1_valid;
    logic [1:0]  b_req1_shape, b_resp1_status;
    logic [4:0]  b_req1_operation;
    logic        b_sp_write, b_sp_read, b_sp_error;
    logic [31:0] b_sp_write_data, b_sp_read_data;
    logic [7:0]  b_reject_count;

    shape_sfr_arbiter #(.READBACK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_shape(req0_shape), .req0_operation(req0_operation),
        .resp0_valid(resp0_valid), .resp0_status(resp0_status),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_shape(req1_shape), .req1_operation(req1_operation),
        .resp1_valid(resp1_valid), .resp1_status(resp1_status),
        .sp_write(sp_write), .sp_write_data(sp_write_data),
        .sp_read(sp_read), .sp_read_data(sp_read_data),
        .sp_error(sp_error), .reject_count(reject_count)
    );

    shape_sfr_arbiter #(.READBACK(1'b0)) dut_nrb (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_shape(b_req0_shape), .req0_operation(b_req0_operation),
        .resp0_valid(b_resp0_valid), .resp0_status(b_resp0_status),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_shape(b_req1_shape), .req1_operation(b_req1_operation),
        .resp1_valid(b_resp1_valid), .resp1_status(b_resp1_status),
        .sp_write(b_sp_write), .sp_write_data(b_sp_write_data),
        .sp_read(b_sp_read), .sp_read_data(b_sp_read_data),
        .sp_error(b_sp_error), .reject_count(b_reject_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rej     = 0;   // rejected responses expected from the read-back build
    int b_rej   = 0;   // same for the no-read-back build
    int last    = 1;   // model of who was served last
    int b_read_cnt = 0;

    // Shape processor model: shape 3 is illegal and silently dropped;
    // read data is only meaningful the cycle after sp_read.
    logic [31:0] sfr = 32'h0;
    bit corrupt_rd = 1'b0;
    always @(posedge clk) begin
        if (sp_write && sp_write_data[17:16] != 2'b11) sfr <= sp_write_data;
        if (sp_read) sp_read_data <= corrupt_rd ? (sfr ^ 32'h1) : sfr;
        else         sp_read_data <= $urandom;
        b_sp_read_data <= $urandom;
        if (b_sp_read) b_read_cnt <= b_read_cnt + 1;
    end

    function automatic logic [7:0] sat(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present requests and check the grant predicted by round-robin.
    task automatic issue(input bit v0, input bit v1,
                         input logic [1:0] s0, input logic [4:0] o0,
                         input logic [1:0] s1, input logic [4:0] o1,
                         output int id);
        req0_valid = v0; req0_shape = s0; req0_operation = o0;
        req1_valid = v1; req1_shape = s1; req1_operation = o1;
        if (v0 && v1) id = 1 - last;
        else          id = v0 ? 0 : 1;
        last = id;
        #1;
        chk("ready0", 32'(req0_ready), 32'(id == 0));
        chk("ready1", 32'(req1_ready), 32'(id == 1));
    endtask

    // Follow a granted command from T+1 to T+5 on the read-back build.
    task automatic finish_cmd(input int id, input logic [1:0] sh, input logic [4:0] op,
                              input bit err, input bit corrupt);
        logic [31:0] wd;
        logic [1:0]  st;
        logic [1:0]  rv;
        wd = {14'b0, sh, 11'b0, op};
        st = err ? 2'b10 : ((sh == 2'b11 || corrupt) ? 2'b01 : 2'b00);
        rv = (id == 0) ? 2'b01 : 2'b10;
        corrupt_rd = corrupt;
        tick();
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("write_strobe", 32'(sp_write), 1);
        chk("write_data", sp_write_data, wd);
        chk("read_early", 32'(sp_read), 0);
        chk("ready_busy_w", 32'({req1_ready, req0_ready}), 0);
        tick();
        chk("read_strobe", 32'(sp_read), 1);
        chk("write_once", 32'(sp_write), 0);
        chk("ready_busy_r", 32'({req1_ready, req0_ready}), 0);
        tick();
        sp_error = err;
        chk("read_once", 32'(sp_read), 0);
        chk("resp_early", 32'({resp1_valid, resp0_valid}), 0);
        tick();
        sp_error = 1'b0;
        corrupt_rd = 1'b0;
        chk("resp_port", 32'({resp1_valid, resp0_valid}), 32'(rv));
        chk("resp_status", 32'((id == 0) ? resp0_status : resp1_status), 32'(st));
        chk("ready_busy_p", 32'({req1_ready, req0_ready}), 0);
        if (st != 2'b00) rej++;
        tick();
        chk("resp_pulse", 32'({resp1_valid, resp0_valid}), 0);
        chk("reject_count", 32'(reject_count), 32'(sat(rej)));
    endtask

    // One command on the no-read-back build, single requester.
    task automatic b_cmd(input int id, input logic [1:0] sh, input logic [4:0] op, input bit err);
        logic [31:0] wd;
        logic [1:0]  st;
        logic [1:0]  rv;
        wd = {14'b0, sh, 11'b0, op};
        st = err ? 2'b10 : 2'b00;
        rv = (id == 0) ? 2'b01 : 2'b10;
        b_req0_valid = (id == 0); b_req0_shape = sh; b_req0_operation = op;
        b_req1_valid = (id == 1); b_req1_shape = sh; b_req1_operation = op;
        #1;
        chk("b_ready", 32'({b_req1_ready, b_req0_ready}), 32'(rv));
        tick();
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        b_sp_error = err;
        chk("b_write_strobe", 32'(b_sp_write), 1);
        chk("b_write_data", b_sp_write_data, wd);
        chk("b_resp_early", 32'({b_resp1_valid, b_resp0_valid}), 0);
        tick();
        b_sp_error = 1'b0;
        chk("b_resp_port", 32'({b_resp1_valid, b_resp0_valid}), 32'(rv));
        chk("b_resp_status", 32'((id == 0) ? b_resp0_status : b_resp1_status), 32'(st));
        chk("b_write_once", 32'(b_sp_write), 0);
        if (st != 2'b00) b_rej++;
        tick();
        chk("b_resp_pulse", 32'({b_resp1_valid, b_resp0_valid}), 0);
        chk("b_reject_count", 32'(b_reject_count), 32'(sat(b_rej)));
    endtask

    initial begin
        int id;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_shape = '0; req0_operation = '0;
        req1_valid = 1'b1; req1_shape = '0; req1_operation = '0;
        sp_error = 1'b0;
        b_req0_valid = 1'b0; b_req0_shape = '0; b_req0_operation = '0;
        b_req1_valid = 1'b0; b_req1_shape = '0; b_req1_operation = '0;
        b_sp_error = 1'b0;
        repeat (3) tick();

        // Reset state, with both requesters asking.
        chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
        chk("rst_strobes", 32'({sp_write, sp_read}), 0);
        chk("rst_wdata", sp_write_data, 0);
        chk("rst_resp", 32'({resp1_valid, resp0_valid, resp1_status, resp0_status}), 0);
        chk("rst_count", 32'(reject_count), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Legal command from requester 0, then illegal shape from requester 1.
        issue(1'b1, 1'b0, 2'b01, 5'b00001, 2'b00, 5'b0, id);
        finish_cmd(id, 2'b01, 5'b00001, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 2'b00, 5'b0, 2'b11, 5'b00000, id);
        finish_cmd(id, 2'b11, 5'b00000, 1'b0, 1'b0);

        // Two rounds of ties: served alternately.
        for (int r = 0; r < 2; r++) begin
            issue(1'b1, 1'b1, 2'b10, 5'h0a, 2'b01, 5'h13, id);
            finish_cmd(id, (id == 0) ? 2'b10 : 2'b01, (id == 0) ? 5'h0a : 5'h13, 1'b0, 1'b0);
            issue(id == 1, id == 0, 2'b10, 5'h0a, 2'b01, 5'h13, id);
            finish_cmd(id, (id == 0) ? 2'b10 : 2'b01, (id == 0) ? 5'h0a : 5'h13, 1'b0, 1'b0);
        end

        // Processor error with mismatching read-back; mismatch alone; error alone.
        issue(1'b0, 1'b1, 2'b00, 5'b0, 2'b11, 5'h1f, id);
        finish_cmd(id, 2'b11, 5'h1f, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 2'b00, 5'h07, 2'b00, 5'b0, id);
        finish_cmd(id, 2'b00, 5'h07, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 2'b10, 5'h02, 2'b00, 5'b0, id);
        finish_cmd(id, 2'b10, 5'h02, 1'b1, 1'b0);

        // Reset while the command sits in READ.
        issue(1'b0, 1'b1, 2'b00, 5'b0, 2'b10, 5'h05, id);
        tick();
        req1_valid = 1'b0;
        chk("inflight_write", 32'(sp_write), 1);
        tick();
        chk("inflight_read", 32'(sp_read), 1);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mid_rst_strobes", 32'({sp_write, sp_read}), 0);
        chk("mid_rst_wdata", sp_write_data, 0);
        chk("mid_rst_resp", 32'({resp1_valid, resp0_valid, resp1_status, resp0_status}), 0);
        chk("mid_rst_count", 32'(reject_count), 0);
        chk("mid_rst_ready", 32'({req1_ready, req0_ready}), 0);
        rej = 0;
        b_rej = 0;
        last = 1;
        repeat (3) begin
            tick();
            chk("rst_hold_resp", 32'({resp1_valid, resp0_valid}), 0);
            chk("rst_hold_ready", 32'({req1_ready, req0_ready}), 0);
        end
        rst_n = 1'b1;
        issue(1'b1, 1'b1, 2'b01, 5'h11, 2'b10, 5'h05, id);
        finish_cmd(id, (id == 0) ? 2'b01 : 2'b10, (id == 0) ? 5'h11 : 5'h05, 1'b0, 1'b0);
        issue(id == 1, id == 0, 2'b01, 5'h11, 2'b10, 5'h05, id);
        finish_cmd(id, (id == 0) ? 2'b01 : 2'b10, (id == 0) ? 5'h11 : 5'h05, 1'b0, 1'b0);

        // Randomized mix of lone and tied requests.
        for (int k = 0; k < 40; k++) begin
            int mode;
            int w;
            logic [1:0] s0, s1;
            logic [4:0] o0, o1;
            mode = int'($urandom_range(0, 2));
            s0 = 2'($urandom_range(0, 3));
            s1 = 2'($urandom_range(0, 3));
            o0 = 5'($urandom);
            o1 = 5'($urandom);
            issue(mode != 1, mode != 0, s0, o0, s1, o1, w);
            finish_cmd(w, (w == 0) ? s0 : s1, (w == 0) ? o0 : o1,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            if (mode == 2) begin
                issue(w == 1, w == 0, s0, o0, s1, o1, w);
                finish_cmd(w, (w == 0) ? s0 : s1, (w == 0) ? o0 : o1,
                           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            end
        end

        // Enough rejected commands to saturate the counter.
        for (int k = 0; k < 260; k++) begin
            int w;
            bit pick;
            logic [4:0] o;
            pick = bit'($urandom_range(0, 1));
            o = 5'($urandom);
            issue(!pick, pick, 2'b11, o, 2'b11, o, w);
            finish_cmd(w, 2'b11, o, 1'b0, 1'b0);
        end

        // No-read-back build: illegal shape is not detected, sp_error in WRITE is.
        b_cmd(0, 2'b01, 5'h01, 1'b0);
        b_cmd(1, 2'b11, 5'h00, 1'b0);
        b_cmd(1, 2'b10, 5'h1c, 1'b1);
        for (int k = 0; k < 10; k++) begin
            b_cmd(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
                  $urandom_range(0, 2) == 0);
        end
        chk("b_no_read", 32'(b_read_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
